// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake bundle for the shift-and-add multiplier.
// The master issues operands and start; the slave returns status and the product.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 10
);
    logic               start;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a_in, b_in,
        input  busy, done, product
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one add-shift step per cycle,
// WIDTH steps per product, with a start/busy/done handshake.
module shift_add_multiplier #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_add_multiplier_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH:0]     sum;

    // Carry out of the add lands in sum[WIDTH] and is shifted down into the accumulator.
    always_comb begin
        sum = {1'b0, acc[WIDTH-1:0]} + (q[0] ? {1'b0, a} : {(WIDTH + 1){1'b0}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a     <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a     <= bus.a_in;
                        q     <= bus.b_in;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= {1'b0, sum[WIDTH:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        p     <= {sum, q[WIDTH-1:1]};
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE);
    assign bus.product = p;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed scenarios plus random
// operands compared against a plain a*b reference with fixed handshake timing.
module tb_shift_add_multiplier;
    localparam int WIDTH = 10;
    localparam int CNT_W = 4;
    localparam int LAT   = WIDTH;      // accept edge to done sample
    localparam int BUSYN = WIDTH + 1;  // busy cycles per operation

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

    shift_add_multiplier #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*WIDTH-1:0] ref_mul(input int unsigned x, input int unsigned y);
        longint unsigned r;
        r = longint'(x) * longint'(y);
        return r[2*WIDTH-1:0];
    endfunction

    // Called #1 after an edge with the DUT idle; returns done latency, busy length, product.
    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output int lat, output int busy_cnt,
                         output logic [2*WIDTH-1:0] prod);
        lat      = -1;
        busy_cnt = 0;
        prod     = 'x;
        bus.start = 1'b1;
        bus.a_in  = x;
        bus.b_in  = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = WIDTH'($urandom);
        bus.b_in  = WIDTH'($urandom);
        for (int k = 0; k <= 40; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done && lat < 0) begin
                lat  = k;
                prod = bus.product;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b product=%0d, required 0/0/0",
                     bus.busy, bus.done, bus.product);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [2*WIDTH-1:0] pr;
        do_op(10'd5, 10'd3, lat, bc, pr);
        checks++;
        if (pr !== 20'd15) begin
            errors++;
            $display("FAIL basic_product: got %0d, required 15", pr);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required %0d", lat, LAT);
        end
        checks++;
        if (bc !== BUSYN) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d, required %0d", bc, BUSYN);
        end
        checks++;
        if (bus.product !== 20'd15) begin
            errors++;
            $display("FAIL basic_hold: got %0d, required 15", bus.product);
        end
    endtask

    task automatic test_abort_reset();
        int lat, bc;
        logic [2*WIDTH-1:0] pr;
        bus.start = 1'b1;
        bus.a_in  = 10'd37;
        bus.b_in  = 10'd19;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b product=%0d, required 0/0/0",
                     bus.busy, bus.done, bus.product);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(10'd6, 10'd7, lat, bc, pr);
        checks++;
        if (pr !== 20'd42 || lat !== LAT) begin
            errors++;
            $display("FAIL after_reset_op: product=%0d lat=%0d, required 42 at %0d",
                     pr, lat, LAT);
        end
    endtask

    task automatic test_corners();
        int lat, bc;
        logic [2*WIDTH-1:0] pr;
        do_op(10'd1023, 10'd1023, lat, bc, pr);
        checks++;
        if (pr !== 20'hFF801) begin
            errors++;
            $display("FAIL max_operands: got %0d, required 1046529", pr);
        end
        do_op(10'd0, 10'd777, lat, bc, pr);
        checks++;
        if (pr !== '0 || lat !== LAT) begin
            errors++;
            $display("FAIL zero_a: product=%0d lat=%0d, required 0 at %0d", pr, lat, LAT);
        end
        do_op(10'd777, 10'd0, lat, bc, pr);
        checks++;
        if (pr !== '0 || lat !== LAT) begin
            errors++;
            $display("FAIL zero_b: product=%0d lat=%0d, required 0 at %0d", pr, lat, LAT);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        ndone = 0;
        bus.start = 1'b1;
        bus.a_in  = 10'd2;
        bus.b_in  = 10'd9;
        @(posedge clk);
        #1;
        bus.a_in = 10'd100;
        bus.b_in = 10'd100;
        // Keep requesting through CALC and DONE; release once back in IDLE.
        for (int k = 1; k <= 25; k++) begin
            bus.start = (k <= LAT) ? ((k % 2) == 0 || k == LAT) : 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ignore_start_pulses: done pulses %0d, required 1", ndone);
        end
        checks++;
        if (bus.product !== 20'd18 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_result: product=%0d busy=%b, required 18 idle",
                     bus.product, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [2*WIDTH-1:0] p1, p2, pmid;
        d1 = -1;
        d2 = -1;
        pmid = 'x;
        bus.start = 1'b1;
        bus.a_in  = 10'd3;
        bus.b_in  = 10'd4;
        @(posedge clk);
        #1;
        bus.a_in = 10'd1023;
        bus.b_in = 10'd1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 16) pmid = bus.product;
            if (bus.done) begin
                if (d1 < 0) begin
                    d1 = k;
                    p1 = bus.product;
                end else if (d2 < 0) begin
                    d2 = k;
                    p2 = bus.product;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (p1 !== 20'd12 || d1 !== LAT) begin
            errors++;
            $display("FAIL b2b_first: product=%0d at %0d, required 12 at %0d", p1, d1, LAT);
        end
        checks++;
        if (p2 !== 20'd1023 || (d2 - d1) !== WIDTH + 2) begin
            errors++;
            $display("FAIL b2b_second: product=%0d gap=%0d, required 1023 gap %0d",
                     p2, d2 - d1, WIDTH + 2);
        end
        checks++;
        if (pmid !== 20'd12) begin
            errors++;
            $display("FAIL b2b_hold: product=%0d between pulses, required 12", pmid);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [2*WIDTH-1:0] pr, exp_p;
        logic [WIDTH-1:0] x, y;
        for (int i = 0; i < 20; i++) begin
            x = WIDTH'($urandom_range(0, 1023));
            y = WIDTH'($urandom_range(0, 1023));
            exp_p = ref_mul(x, y);
            do_op(x, y, lat, bc, pr);
            checks++;
            if (pr !== exp_p || lat !== LAT || bc !== BUSYN) begin
                errors++;
                $display("FAIL random_%0d: %0d*%0d got %0d lat %0d busy %0d, required %0d lat %0d busy %0d",
                         i, x, y, pr, lat, bc, exp_p, LAT, BUSYN);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_abort_reset();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
